// File: rtl/hazard_scoreboard_unit_if.sv
// Handshake bundle between the ID-stage pipeline control and the hazard
// scoreboard. The pipeline side (master) presents the decoded ID instruction
// and EX events; the scoreboard side (slave) returns hold/flush/bubble controls.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int PERF_W     = 16
);
  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]            id_src_valid;
  logic [REG_ADDR_W-1:0]         id_rd_addr;
  logic                          id_reg_write;
  logic                          id_mem_read;
  logic                          id_mc;
  logic                          mc_done;
  logic                          ex_branch_taken;
  logic                          stall_pc;
  logic                          bubble_id_ex;
  logic                          freeze_ex;
  logic                          flush_if_id;
  logic                          flush_id_ex;
  logic                          mc_error;
  logic [PERF_W-1:0]             stall_count;

  modport master (
    output id_valid, id_src_addr, id_src_valid, id_rd_addr, id_reg_write,
           id_mem_read, id_mc, mc_done, ex_branch_taken,
    input  stall_pc, bubble_id_ex, freeze_ex, flush_if_id, flush_id_ex,
           mc_error, stall_count
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_valid, id_rd_addr, id_reg_write,
           id_mem_read, id_mc, mc_done, ex_branch_taken,
    output stall_pc, bubble_id_ex, freeze_ex, flush_if_id, flush_id_ex,
           mc_error, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard controller beside the ID stage.
// Tracks outstanding load destinations with per-register down-counters,
// sequences multi-cycle EX operations with a busy FSM and timeout, gives
// taken-branch flushes priority over load-use stalls, and counts bubbles.
//
// state   | meaning
// IDLE    | no multi-cycle op in EX; branches may flush
// MC_BUSY | multi-cycle op in EX; pipe frozen until mc_done or timeout
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int PERF_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int CNT_W    = $clog2(LOAD_LATENCY + 1);
  localparam int TMR_W    = $clog2(MC_TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               err_set;
  logic [CNT_W-1:0]   cnt [NUM_REGS];
  logic               load_use;
  logic               freeze;
  logic               flush;
  logic               stall;
  logic               bubble;
  logic               issue;
  logic               load_set;
  logic               mc_error_q;
  logic [PERF_W-1:0]  stall_count_q;

  // A source hazard exists when any read port names a register with a load still in flight.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz.id_src_valid[i] &&
          (hz.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          (cnt[hz.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0)) begin
        load_use = 1'b1;
      end
    end
    load_use = load_use & hz.id_valid;
  end

  // Pipeline controls; a taken branch outranks a load-use stall, but not a freeze.
  always_comb begin
    freeze   = (state == MC_BUSY) && !hz.mc_done;
    flush    = hz.ex_branch_taken && (state == IDLE);
    stall    = freeze || (load_use && !flush);
    bubble   = load_use && !freeze && !flush;
    issue    = hz.id_valid && !stall && !flush;
    load_set = issue && hz.id_mem_read && hz.id_reg_write && (hz.id_rd_addr != '0);
  end

  assign hz.stall_pc     = stall;
  assign hz.bubble_id_ex = bubble;
  assign hz.freeze_ex    = freeze;
  assign hz.flush_if_id  = flush;
  assign hz.flush_id_ex  = flush;
  assign hz.mc_error     = mc_error_q;
  assign hz.stall_count  = stall_count_q;

  // Per-register countdown: an issuing load reloads its rd, everything else drains, even when frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (load_set && (hz.id_rd_addr == REG_ADDR_W'(r))) begin
          cnt[r] <= CNT_W'(LOAD_LATENCY);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Multi-cycle sequencer next state; mc_done beats the timeout when both land together.
  always_comb begin
    state_n = state;
    timer_n = timer;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (issue && hz.id_mc) begin
          state_n = MC_BUSY;
          timer_n = '0;
        end
      end
      MC_BUSY: begin
        if (hz.mc_done) begin
          // freeze is low here, so the next op can issue straight back in
          timer_n = '0;
          state_n = (issue && hz.id_mc) ? MC_BUSY : IDLE;
        end else if (timer == TMR_W'(MC_TIMEOUT - 1)) begin
          state_n = IDLE;
          timer_n = '0;
          err_set = 1'b1;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Sequencer state, timer and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      mc_error_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (err_set) begin
        mc_error_q <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which a load-use bubble was actually inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (bubble && (stall_count_q != {PERF_W{1'b1}})) begin
      stall_count_q <= stall_count_q + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (load latency 1 with a
// 3-bit perf counter, load latency 3 with an 8-cycle timeout) driven from one
// vector table; expected outputs are queued as each row is driven and popped
// when the outputs are sampled.
module tb_hazard_scoreboard_unit;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  // {stall_pc, bubble_id_ex, freeze_ex, flush_if_id, flush_id_ex, mc_error}
  localparam logic [5:0] C0   = 6'b000000;
  localparam logic [5:0] CST  = 6'b110000;
  localparam logic [5:0] CFL  = 6'b000110;
  localparam logic [5:0] CFZ  = 6'b101000;
  localparam logic [5:0] CER  = 6'b000001;
  localparam logic [5:0] CFZE = 6'b101001;

  typedef struct {
    string      name;
    bit         sel;
    bit         rst;
    bit         valid;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] sv;
    logic [4:0] rd;
    bit         rw;
    bit         mr;
    bit         mc;
    bit         done;
    bit         br;
    logic [5:0] ctl;
    int         cnt;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel;
    logic [5:0] ctl;
    int         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .PERF_W(3))  if_a ();
  hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .NUM_SRC(2), .PERF_W(16)) if_b ();

  hazard_scoreboard_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LATENCY(1), .MC_TIMEOUT(64), .PERF_W(3)
  ) dut_a (.clk(clk), .rst(rst), .hz(if_a));

  hazard_scoreboard_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LATENCY(3), .MC_TIMEOUT(8), .PERF_W(16)
  ) dut_b (.clk(clk), .rst(rst), .hz(if_b));

  function automatic vec_t mk(string name, bit sel, bit r, bit v,
                              logic [4:0] s0, logic [4:0] s1, logic [1:0] sv,
                              logic [4:0] rd, bit rw, bit mr, bit mc, bit done,
                              bit br, logic [5:0] ctl, int cnt);
    vec_t t;
    t.name = name; t.sel = sel; t.rst = r; t.valid = v;
    t.s0 = s0; t.s1 = s1; t.sv = sv; t.rd = rd;
    t.rw = rw; t.mr = mr; t.mc = mc; t.done = done; t.br = br;
    t.ctl = ctl; t.cnt = cnt;
    return t;
  endfunction

  task automatic drive_idle();
    if_a.id_valid = 1'b0; if_a.id_src_addr = '0; if_a.id_src_valid = '0;
    if_a.id_rd_addr = '0; if_a.id_reg_write = 1'b0; if_a.id_mem_read = 1'b0;
    if_a.id_mc = 1'b0; if_a.mc_done = 1'b0; if_a.ex_branch_taken = 1'b0;
    if_b.id_valid = 1'b0; if_b.id_src_addr = '0; if_b.id_src_valid = '0;
    if_b.id_rd_addr = '0; if_b.id_reg_write = 1'b0; if_b.id_mem_read = 1'b0;
    if_b.id_mc = 1'b0; if_b.mc_done = 1'b0; if_b.ex_branch_taken = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst;
    drive_idle();
    if (v.sel == A) begin
      if_a.id_valid = v.valid; if_a.id_src_addr = {v.s1, v.s0}; if_a.id_src_valid = v.sv;
      if_a.id_rd_addr = v.rd; if_a.id_reg_write = v.rw; if_a.id_mem_read = v.mr;
      if_a.id_mc = v.mc; if_a.mc_done = v.done; if_a.ex_branch_taken = v.br;
    end else begin
      if_b.id_valid = v.valid; if_b.id_src_addr = {v.s1, v.s0}; if_b.id_src_valid = v.sv;
      if_b.id_rd_addr = v.rd; if_b.id_reg_write = v.rw; if_b.id_mem_read = v.mr;
      if_b.id_mc = v.mc; if_b.mc_done = v.done; if_b.ex_branch_taken = v.br;
    end
    e.name = v.name; e.sel = v.sel; e.ctl = v.ctl; e.cnt = v.cnt;
    exp_q.push_back(e);
    #2;
    check_outputs();
  endtask

  task automatic check_outputs();
    exp_t       e;
    logic [5:0] got_ctl;
    int         got_cnt;
    e = exp_q.pop_front();
    if (e.sel == A) begin
      got_ctl = {if_a.stall_pc, if_a.bubble_id_ex, if_a.freeze_ex,
                 if_a.flush_if_id, if_a.flush_id_ex, if_a.mc_error};
      got_cnt = int'(if_a.stall_count);
    end else begin
      got_ctl = {if_b.stall_pc, if_b.bubble_id_ex, if_b.freeze_ex,
                 if_b.flush_if_id, if_b.flush_id_ex, if_b.mc_error};
      got_cnt = int'(if_b.stall_count);
    end
    n_tests++;
    if (got_ctl !== e.ctl) begin
      n_fail++;
      $display("FAIL %s ctl: got %b expected %b (stall,bubble,freeze,flush_if,flush_ex,err)",
               e.name, got_ctl, e.ctl);
    end
    n_tests++;
    if (got_cnt != e.cnt) begin
      n_fail++;
      $display("FAIL %s stall_count: got %0d expected %0d", e.name, got_cnt, e.cnt);
    end
  endtask

  initial begin
    int c;
    drive_idle();

    // reset state: flush follows the branch input, everything else low
    vecs.push_back(mk("rst_br_a",   A,1,0, 0,0,2'b00, 0,0,0,0,0,1, CFL,0));
    vecs.push_back(mk("rst_lw_b",   B,1,1, 0,0,2'b00, 7,1,1,0,0,0, C0,0));

    // instance A, load latency 1
    vecs.push_back(mk("a_lw5",      A,0,1, 0,0,2'b00, 5,1,1,0,0,0, C0,0));
    vecs.push_back(mk("a_use5_stl", A,0,1, 5,1,2'b11, 6,1,0,0,0,0, CST,0));
    vecs.push_back(mk("a_use5_iss", A,0,1, 5,1,2'b11, 6,1,0,0,0,0, C0,1));
    vecs.push_back(mk("a_lw5_b",    A,0,1, 0,0,2'b00, 5,1,1,0,0,0, C0,1));
    vecs.push_back(mk("a_indep",    A,0,1, 1,2,2'b11, 6,1,0,0,0,0, C0,1));
    vecs.push_back(mk("a_lw9",      A,0,1, 0,0,2'b00, 9,1,1,0,0,0, C0,1));
    vecs.push_back(mk("a_flush_lu", A,0,1, 9,1,2'b11, 6,1,0,0,0,1, CFL,1));
    vecs.push_back(mk("a_after_fl", A,0,1, 9,1,2'b11, 6,1,0,0,0,0, C0,1));
    vecs.push_back(mk("a_lw10_fl",  A,0,1, 0,0,2'b00,10,1,1,0,0,1, CFL,1));
    vecs.push_back(mk("a_use10",    A,0,1,10,0,2'b01, 6,1,0,0,0,0, C0,1));
    vecs.push_back(mk("a_lw_x0",    A,0,1, 0,0,2'b00, 0,1,1,0,0,0, C0,1));
    vecs.push_back(mk("a_use_x0",   A,0,1, 0,0,2'b11, 6,1,0,0,0,0, C0,1));
    vecs.push_back(mk("a_lw11",     A,0,1, 0,0,2'b00,11,1,1,0,0,0, C0,1));
    vecs.push_back(mk("a_lw12_stl", A,0,1,11,0,2'b01,12,1,1,0,0,0, CST,1));
    vecs.push_back(mk("a_lw12_iss", A,0,1,11,0,2'b01,12,1,1,0,0,0, C0,2));
    vecs.push_back(mk("a_inv_rd12", A,0,0,12,0,2'b01, 6,1,0,0,0,0, C0,2));
    vecs.push_back(mk("a_use12_p1", A,0,1, 0,12,2'b10,6,1,0,0,0,0, C0,2));

    // self-dependent load on x13: bubble every other cycle, counter saturates at 7
    c = 2;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) begin
        vecs.push_back(mk("a_sat_bub", A,0,1,13,0,2'b01,13,1,1,0,0,0, CST,c));
        c = (c < 7) ? c + 1 : 7;
      end else begin
        vecs.push_back(mk("a_sat_iss", A,0,1,13,0,2'b01,13,1,1,0,0,0, C0,c));
      end
    end
    vecs.push_back(mk("a_sat_hold", A,0,0, 0,0,2'b00, 0,0,0,0,0,0, C0,7));

    // instance B, load latency 3
    vecs.push_back(mk("b_lw7",      B,0,1, 0,0,2'b00, 7,1,1,0,0,0, C0,0));
    vecs.push_back(mk("b_use7_s1",  B,0,1, 2,7,2'b11, 1,1,0,0,0,0, CST,0));
    vecs.push_back(mk("b_use7_s2",  B,0,1, 2,7,2'b11, 1,1,0,0,0,0, CST,1));
    vecs.push_back(mk("b_use7_s3",  B,0,1, 2,7,2'b11, 1,1,0,0,0,0, CST,2));
    vecs.push_back(mk("b_use7_iss", B,0,1, 2,7,2'b11, 1,1,0,0,0,0, C0,3));
    vecs.push_back(mk("b_lw7_b",    B,0,1, 0,0,2'b00, 7,1,1,0,0,0, C0,3));
    vecs.push_back(mk("b_use_x8",   B,0,1, 2,8,2'b11, 1,1,0,0,0,0, C0,3));
    vecs.push_back(mk("b_use_x0",   B,0,1, 2,0,2'b11, 1,1,0,0,0,0, C0,3));
    vecs.push_back(mk("b_nop",      B,0,0, 0,0,2'b00, 0,0,0,0,0,0, C0,3));
    vecs.push_back(mk("b_lw3",      B,0,1, 0,0,2'b00, 3,1,1,0,0,0, C0,3));
    vecs.push_back(mk("b_lw4",      B,0,1, 0,0,2'b00, 4,1,1,0,0,0, C0,3));
    vecs.push_back(mk("b_use3_stl", B,0,1, 3,0,2'b01, 1,1,0,0,0,0, CST,3));
    vecs.push_back(mk("b_use4_stl", B,0,1, 4,0,2'b01, 1,1,0,0,0,0, CST,4));
    vecs.push_back(mk("b_use4_stl2",B,0,1, 4,0,2'b01, 1,1,0,0,0,0, CST,5));
    vecs.push_back(mk("b_use34_iss",B,0,1, 3,4,2'b11, 1,1,0,0,0,0, C0,6));

    // divide, done on the fifth busy cycle
    vecs.push_back(mk("b_div",      B,0,1, 0,0,2'b00, 9,1,0,1,0,0, C0,6));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("b_div_frz",B,0,1, 9,0,2'b01,10,1,0,0,0,0, CFZ,6));
    vecs.push_back(mk("b_div_done", B,0,1, 9,0,2'b01,10,1,0,0,1,0, C0,6));
    vecs.push_back(mk("b_idle_br",  B,0,0, 0,0,2'b00, 0,0,0,0,0,1, CFL,6));

    // mc_done on the same cycle the timer expires counts as done
    vecs.push_back(mk("c_div",      B,0,1, 0,0,2'b00, 9,1,0,1,0,0, C0,6));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk("c_div_frz",B,0,1, 9,0,2'b01,10,1,0,0,0,0, CFZ,6));
    vecs.push_back(mk("c_done_exp", B,0,1, 9,0,2'b01,10,1,0,0,1,0, C0,6));
    vecs.push_back(mk("c_idle_br",  B,0,0, 0,0,2'b00, 0,0,0,0,0,1, CFL,6));

    // back-to-back ops, then the second one times out
    vecs.push_back(mk("d_div1",     B,0,1, 0,0,2'b00, 9,1,0,1,0,0, C0,6));
    vecs.push_back(mk("d_div2_frz", B,0,1, 0,0,2'b00, 9,1,0,1,0,0, CFZ,6));
    vecs.push_back(mk("d_div2_iss", B,0,1, 0,0,2'b00, 9,1,0,1,1,0, C0,6));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("d_tmo_frz",B,0,1, 9,0,2'b01,10,1,0,0,0,(i == 2), CFZ,6));
    vecs.push_back(mk("d_tmo_err",  B,0,1, 9,0,2'b01,10,1,0,0,0,0, CER,6));
    vecs.push_back(mk("d_done_idle",B,0,0, 0,0,2'b00, 0,0,0,0,1,0, CER,6));

    // reset in the middle of a busy op with a load still counting down
    vecs.push_back(mk("r_lw7",      B,0,1, 0,0,2'b00, 7,1,1,0,0,0, CER,6));
    vecs.push_back(mk("r_div",      B,0,1, 0,0,2'b00, 9,1,0,1,0,0, CER,6));
    vecs.push_back(mk("r_frz_lu",   B,0,1, 7,0,2'b01, 1,1,0,0,0,0, CFZE,6));
    vecs.push_back(mk("r_rst_now",  B,1,1, 7,0,2'b01, 1,1,0,0,0,0, C0,0));
    vecs.push_back(mk("r_use7_free",B,0,1, 7,0,2'b01, 1,1,0,0,0,0, C0,0));
    vecs.push_back(mk("r_a_cleared",A,0,0, 0,0,2'b00, 0,0,0,0,0,1, CFL,0));

    foreach (vecs[i]) apply(vecs[i]);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised scoreboard-based hazard controller for the pipelined RISC-V core. It supersedes the purely combinational load-use check. It tracks outstanding load destinations with per-register countdown counters, supports configurable load latency and source-port count, and sequences multi-cycle EX operations (div/mul) with a busy FSM and timeout. It also arbitrates branch flushes against stalls and keeps a saturating stall performance counter. It sits beside the ID stage and drives the PC, IF/ID and ID/EX hold, flush and bubble controls.

## Interface
- REG_ADDR_W, 5: register address width; the register file has 2**REG_ADDR_W entries.
- NUM_SRC, 2: number of source-register ports checked in ID, legal range 1..4.
- LOAD_LATENCY, 1: stall cycles a dependent instruction needs behind a load, legal range 1..7. A value of 1 is the classic 5-stage load-use bubble.
- MC_TIMEOUT, 64: maximum number of MC_BUSY cycles before the operation is abandoned, must be ≥2.
- PERF_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  packed source addresses; port i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_valid  in  NUM_SRC  per-port flag that the instruction reads that source.
- id_rd_addr  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes rd.
- id_mem_read  in  1  the ID instruction is a load.
- id_mc  in  1  the ID instruction is a multi-cycle EX operation.
- mc_done  in  1  the multi-cycle unit finishes in this cycle.
- ex_branch_taken  in  1  a branch resolved taken in EX.
- stall_pc  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- freeze_ex  out  1  hold ID/EX; EX/MEM receives a bubble.
- flush_if_id  out  1  clear IF/ID.
- flush_id_ex  out  1  clear ID/EX.
- mc_error  out  1  sticky flag: a multi-cycle operation timed out.
- stall_count  out  PERF_W  count of effective load-use stall cycles, saturating.

## Operation
**Scoreboard**
- Each register r has a counter cnt[r] of width clog2(LOAD_LATENCY+1).
- Register x0 is never tracked; its counter is always 0.

**Signal definitions**
- issue = id_valid & ~stall_pc & ~flush_id_ex.
- load_use = id_valid & (any i: id_src_valid[i] & src_i≠0 & cnt[src_i]≠0).
- freeze = (state==MC_BUSY) & ~mc_done.

**Outputs (all combinational from state and inputs)**
- flush_if_id = flush_id_ex = ex_branch_taken & (state==IDLE). A taken branch in MC_BUSY is ignored.
- freeze_ex = freeze.
- stall_pc = freeze | (load_use & ~flush_id_ex).
- bubble_id_ex = load_use & ~freeze & ~flush_id_ex.

**Counter update, per edge**
- If issue & id_mem_read & id_reg_write & id_rd_addr≠0: cnt[id_rd_addr] ← LOAD_LATENCY. Setting has priority over decrementing for that register.
- Every other nonzero counter decrements by 1, including during freeze.
- Flushed or stalled instructions never set a counter.

**FSM states: IDLE, MC_BUSY**
- IDLE→MC_BUSY when issue & id_mc. The timer is cleared to 0.
- MC_BUSY→IDLE when mc_done. On that cycle freeze is low, so the pipe advances.
- In MC_BUSY without mc_done, the timer increments. When the timer reaches MC_TIMEOUT-1 and mc_done is still low:
  - the FSM goes to IDLE;
  - mc_error ← 1;
  - freeze drops in the following cycle.
- mc_done in IDLE is ignored.

**Performance counter**
- stall_count increments on every cycle with bubble_id_ex=1.
- It holds at 2**PERF_W-1 once saturated.

## Timing
- Reset (asynchronous, any cycle, including mid-MC_BUSY):
  - all cnt=0, state=IDLE, timer=0, mc_error=0, stall_count=0;
  - therefore stall_pc=bubble_id_ex=freeze_ex=0;
  - the flush outputs follow ex_branch_taken.
- Load-use latency: a load issued at edge k stalls a dependent instruction in ID for exactly LOAD_LATENCY cycles after edge k. The dependent issues at edge k+LOAD_LATENCY+1.
- Independent instructions behind a load are never stalled.
- Multiple pending loads keep independent countdowns.
- Simultaneous branch flush and load_use: the flush wins. There is no stall or bubble, and stall_count does not increment.
- Simultaneous mc_done and timer expiry: this is treated as done. mc_error is unchanged.
- Back-to-back multi-cycle ops: the second id_mc can issue in the mc_done cycle. The FSM then re-enters MC_BUSY at the next edge with timer=0.

## Test plan
- Load-use, LOAD_LATENCY=1: `lw x5` issues, then `add x6,x5,x1` in ID → stall_pc=1 and bubble_id_ex=1 for exactly 1 cycle; stall_count=1.
- LOAD_LATENCY=3, load to x7, dependent on src port 1 → 3 stall cycles. Changing the dependent's source to x0 or x8 → 0 stall cycles.
- Branch flush during stall: ex_branch_taken=1 while load_use=1 → flush_if_id=flush_id_ex=1, stall_pc=0, stall_count unchanged.
- Div issue, mc_done after 5 cycles → freeze_ex=1 for 4 cycles then 0; state returns to IDLE; mc_error=0.
- MC_TIMEOUT=8 with mc_done never asserted → freeze_ex high for 8 cycles, then mc_error=1 and stays set until rst.
- rst asserted mid-MC_BUSY with a load counter nonzero → all outputs return to reset values immediately; a dependent presented next cycle is not stalled.
